spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Shares one `spi_master` between `NUM_REQ` requesters (e.g. the up-counter byte source plus a configuration or debug source) using round-robin arbitration. Each grant covers one multi-byte frame. The block owns the slave-select line and holds it low for the whole frame. It sequences the master's `start`/`tx_ready`/`done` handshake byte by byte and returns each received byte to the granted requester. It sits between the requesters and `spi_master` inside the master top level.

## Interface

**Parameters**
- `NUM_REQ`, default 2: number of requesters (2–8).
- `SS_SETUP`, default 2: clocks between `ss` falling and the first `spi_start` (minimum 1).
- `SS_HOLD`, default 2: clocks between the last `spi_done` and `ss` rising (minimum 1).
- `TIMEOUT`, default 1024: watchdog limit in clocks per byte; used only with `SPI_ARB_TIMEOUT_EN`.

**Ports**
- `clk` input, 1: system clock. One clock domain.
- `reset` input, 1: synchronous, active-high.
- `req` input, `NUM_REQ`: requester i wants the bus / has a byte pending.
- `req_data` input, `NUM_REQ*8`: byte of requester i at bits `[8i+7:8i]`.
- `req_last` input, `NUM_REQ`: the pending byte of requester i is the frame's final byte.
- `req_ack` output, `NUM_REQ`: one-cycle pulse; the byte was shifted and `rx_byte` is valid.
- `rx_byte` output, 8: byte received during the acknowledged transfer.
- `grant` output, `NUM_REQ`: one-hot owner of the current frame; all zero when idle.
- `busy` output, 1: high whenever the state is not IDLE.
- `err` output, 1: one-cycle watchdog-abort pulse.
- `spi_start` output, 1: start pulse to `spi_master`.
- `spi_tx_data` output, 8: byte to `spi_master`.
- `spi_tx_ready` input, 1: `spi_master` is idle.
- `spi_done` input, 1: `spi_master` byte-complete pulse.
- `spi_rx_data` input, 8: `spi_master` received byte.
- `ss` output, 1: active-low slave select.

## Operation

**State machine**
- States: IDLE, SETUP, SEND, WAIT, NEXT, HOLD.
- IDLE:
  - If any `req` is high, pick the winner and register it in `grant`.
  - Drive `ss` low, load the setup counter, and go to SETUP.
- SETUP: count `SS_SETUP` clocks, then go to SEND.
- SEND:
  - Wait for `spi_tx_ready`=1.
  - Then pulse `spi_start` for one clock and register `spi_tx_data` = granted `req_data`.
  - Capture granted `req_last` into `last_q`; capture 1 instead if granted `req`=0.
  - Go to WAIT.
- WAIT: on `spi_done`, register `rx_byte` = `spi_rx_data`, pulse `req_ack[grant]` and go to NEXT.
- NEXT (one clock, lets the requester present its next byte):
  - If `last_q`, go to HOLD.
  - Otherwise go to SEND.
- HOLD: count `SS_HOLD` clocks, drive `ss` high, clear `grant`, update the round-robin pointer and go to IDLE.

**Arbitration**
- Round-robin. The search starts at `ptr+1` mod `NUM_REQ` and the first high `req` wins.
- `ptr` takes the index of the finished frame's owner.
- Reset value of `ptr` is `NUM_REQ-1`, so requester 0 wins the first contention.

**Rules and boundary conditions**
- The grant is fixed for the whole frame. Requests from other requesters are ignored until IDLE.
- Granted `req` dropping mid-frame: the next SEND still starts, with its byte treated as last. If `req` is already low at the next SEND, the frame still sends one byte and then ends.
- `req_last`=1 on the first byte gives a one-byte frame.
- `spi_done` outside WAIT is ignored.
- `spi_tx_ready`=0 in SEND stalls indefinitely; `ss` stays low.
- Reset mid-frame: every output returns to its reset value on the next edge and `ptr` returns to `NUM_REQ-1`.

## Timing

**Reset values**
- `ss`=1, `busy`=0, `err`=0, all other outputs 0.

**Latency (edges counted from the edge that samples `req` in IDLE, edge 0)**
- Edge 0: `grant` and `ss`=0 become visible.
- Edge `SS_SETUP`: state enters SEND.
- Next edge with `spi_tx_ready`=1 in SEND: `spi_start` becomes visible for one cycle.
- Edge that samples `spi_done`: `req_ack` and `rx_byte` become visible.
- Between bytes: at least 2 clocks from `req_ack` to the next `spi_start` (NEXT plus SEND).
- After the last `req_ack`: `ss` rises after NEXT plus `SS_HOLD` clocks.
- `grant` clears together with `ss` rising; a new grant can appear 1 clock later.

**Requester rules**
- `req_data`/`req_last` must be stable from `req` high until the `req_ack` of that byte.
- The next byte must be presented by the clock after `req_ack`.

## Configuration

`SPI_ARB_TIMEOUT_EN`:
- **Defined:** WAIT counts clocks. If the count reaches `TIMEOUT` without `spi_done`:
  - pulse `err` for 1 clock;
  - do not pulse `req_ack`;
  - drive `ss` high, clear `grant`, update `ptr`, and go to IDLE (HOLD is skipped).
  - The counter reloads on every entry to WAIT.
- **Undefined:** WAIT waits forever, `err` is tied to 0, and no counter is instantiated.

## Test plan

- **Single byte:** after reset, `req`=01, `req_data[7:0]`=0xA5, `req_last`=1; model returns rx 0x3C → exactly one `spi_start` with `spi_tx_data`=0xA5, `ss` low at edge 0, one `req_ack`=01 with `rx_byte`=0x3C, `ss` high `SS_HOLD` clocks after NEXT, `busy`=0 afterwards.
- **Three-byte frame:** requester 1 sends 0x11, 0x22, 0x33 (`req_last` on the third) → `ss` stays low throughout, three ack pulses, bytes in order, inter-byte gap of at least 2 clocks.
- **Contention:** `req`=11 held continuously, one-byte frames → grants alternate 01, 10, 01, 10 and the first grant is 01.
- **Stall and late request:** `spi_tx_ready`=0 for 20 clocks in SEND → no `spi_start`, `ss` stays low. Requester 1 raising `req` mid-frame of requester 0 gets no grant until the frame ends.
- **Reset mid-frame:** assert `reset` during WAIT → next edge `ss`=1, `grant`=0, `spi_start`=0. After release with `req`=11, requester 0 wins.
- **Timeout (`SPI_ARB_TIMEOUT_EN`, `TIMEOUT`=16):** `spi_done` never asserted → `err` pulses 16 clocks after entering WAIT, no `req_ack`, `ss` high, state returns to IDLE.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters, one frame per grant.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           rx_byte,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 err,
  output logic                 spi_start,
  output logic [7:0]           spi_tx_data,
  input  logic                 spi_tx_ready,
  input  logic                 spi_done,
  input  logic [7:0]           spi_rx_data,
  output logic                 ss
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_ack;
  logic [7:0]         r_rx_byte;
  logic [7:0]         r_tx_data;
  logic               r_start;
  logic               r_ss;
  logic               r_last_q;
  logic [CNT_W-1:0]   r_cnt;

  logic [7:0]         w_bytes [NUM_REQ];
  logic [7:0]         w_gnt_byte;
  logic               w_gnt_req;
  logic               w_gnt_last;

  logic [2*NUM_REQ-1:0] w_req2;
  logic [IDX_W:0]       w_shift;
  logic [2*NUM_REQ-1:0] w_req2_rot;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_win_found;
  int                   w_win_sum;
  logic [IDX_W-1:0]     w_win_idx;
  logic [NUM_REQ-1:0]   w_win_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign w_bytes[gi] = req_data[gi*8 +: 8];
    end
  endgenerate

  assign w_gnt_byte = w_bytes[r_gnt_idx];
  assign w_gnt_req  = req[r_gnt_idx];
  assign w_gnt_last = req_last[r_gnt_idx];

  // Rotate the request vector so bit 0 is the requester just after ptr.
  assign w_req2     = {req, req};
  assign w_shift    = {1'b0, r_ptr} + 1'b1;
  assign w_req2_rot = w_req2 >> w_shift;
  assign w_rot      = w_req2_rot[NUM_REQ-1:0];

  always_comb begin
    w_win_found = 1'b0;
    w_win_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_win_found && w_rot[k]) begin
        w_win_found = 1'b1;
        w_win_sum   = int'(r_ptr) + 1 + k;
      end
    end
    if (w_win_sum >= NUM_REQ) begin
      w_win_sum = w_win_sum - NUM_REQ;
    end
    w_win_idx    = IDX_W'(w_win_sum);
    w_win_onehot = NUM_REQ'(1) << w_win_idx;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] r_wd;
  logic            r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_rx_byte <= '0;
      r_tx_data <= '0;
      r_start   <= 1'b0;
      r_ss      <= 1'b1;
      r_last_q  <= 1'b0;
      r_cnt     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_wd      <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_grant   <= w_win_onehot;
            r_gnt_idx <= w_win_idx;
            r_ss      <= 1'b0;
            r_cnt     <= CNT_W'(SS_SETUP - 1);
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_SEND;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SEND: begin
          if (spi_tx_ready) begin
            r_start   <= 1'b1;
            r_tx_data <= w_gnt_byte;
            // A withdrawn request still gets this byte, but it closes the frame.
            r_last_q  <= w_gnt_req ? w_gnt_last : 1'b1;
            r_state   <= S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            r_wd      <= WD_W'(TIMEOUT - 1);
`endif
          end
        end
        S_WAIT: begin
          if (spi_done) begin
            r_rx_byte <= spi_rx_data;
            r_ack     <= r_grant;
            r_state   <= S_NEXT;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_wd == '0) begin
            r_err   <= 1'b1;
            r_ss    <= 1'b1;
            r_grant <= '0;
            r_ptr   <= r_gnt_idx;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd - 1'b1;
          end
`endif
        end
        S_NEXT: begin
          if (r_last_q) begin
            r_cnt   <= CNT_W'(SS_HOLD - 1);
            r_state <= S_HOLD;
          end else begin
            r_state <= S_SEND;
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_ss    <= 1'b1;
            r_grant <= '0;
            r_ptr   <= r_gnt_idx;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ack     = r_ack;
  assign rx_byte     = r_rx_byte;
  assign grant       = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign spi_start   = r_start;
  assign spi_tx_data = r_tx_data;
  assign ss          = r_ss;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small spi_master responder model.
module tb_spi_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ack;
  logic [7:0]  rx_byte;
  logic [1:0]  grant;
  logic        busy;
  logic        err;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_ready;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        ss;

  int checks = 0;
  int errors = 0;

  spi_arbiter #(
    .NUM_REQ (2),
    .SS_SETUP(2),
    .SS_HOLD (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ack     (req_ack),
    .rx_byte     (rx_byte),
    .grant       (grant),
    .busy        (busy),
    .err         (err),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_tx_ready(spi_tx_ready),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .ss          (ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spi_master model: done arrives a few clocks after start, rx = tx ^ m_xor.
  logic       m_busy;
  int         m_cnt;
  logic [7:0] m_tx;
  logic [7:0] m_xor;
  logic       model_done_en;

  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        spi_done    <= model_done_en;
        spi_rx_data <= m_tx ^ m_xor;
        m_busy      <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (spi_start === 1'b1) begin
      m_busy <= 1'b1;
      m_cnt  <= 3;
      m_tx   <= spi_tx_data;
    end
  end

  int   cyc = 0;
  int   start_cnt = 0;
  int   ack_cnt = 0;
  int   err_cnt = 0;
  int   ss_rise_cnt = 0;
  int   last_ack_cyc = 0;
  logic have_ack = 1'b0;
  logic prev_ss = 1'b1;
  int   gaps [$];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_ss <= ss;
    if (spi_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      if (have_ack) gaps.push_back(cyc - last_ack_cyc);
    end
    if (req_ack !== 2'b00) begin
      ack_cnt      <= ack_cnt + 1;
      last_ack_cyc <= cyc;
      have_ack     <= 1'b1;
    end
    if (err === 1'b1) err_cnt <= err_cnt + 1;
    if (prev_ss === 1'b0 && ss === 1'b1) ss_rise_cnt <= ss_rise_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack === 2'b00 && n < 200);
    chk(tag, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (spi_start !== 1'b1 && n < 200);
    chk(tag, {31'd0, n < 200}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 200);
    chk(tag, {31'd0, n < 200}, 32'd1);
  endtask

  initial begin
    int rise0;
    int s0;
    logic [1:0] exp_g [4];
    logic [7:0] exp_rx [4];
`ifdef SPI_ARB_TIMEOUT_EN
    int a0;
`endif
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rx = '{8'hFA, 8'h40, 8'hFA, 8'h40};

    reset = 1'b1; req = 2'b00; req_data = 16'h0000; req_last = 2'b00;
    spi_tx_ready = 1'b1; m_xor = 8'h99; model_done_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ss", {31'd0, ss}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ack", {30'd0, req_ack}, 32'd0);
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_rx", {24'd0, rx_byte}, 32'd0);
    chk("rst_tx", {24'd0, spi_tx_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte frame from requester 0
    req = 2'b01; req_data = 16'h00A5; req_last = 2'b01;
    @(negedge clk);
    chk("t1_grant_e0", {30'd0, grant}, 32'd1);
    chk("t1_ss_e0", {31'd0, ss}, 32'd0);
    chk("t1_busy_e0", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_start_e1", {31'd0, spi_start}, 32'd0);
    @(negedge clk);
    chk("t1_start_e2", {31'd0, spi_start}, 32'd0);
    @(negedge clk);
    chk("t1_start_e3", {31'd0, spi_start}, 32'd1);
    chk("t1_tx", {24'd0, spi_tx_data}, 32'hA5);
    wait_ack("t1_ack_wait");
    chk("t1_ack", {30'd0, req_ack}, 32'd1);
    chk("t1_rx", {24'd0, rx_byte}, 32'h3C);
    chk("t1_starts", start_cnt, 32'd1);
    req = 2'b00;
    @(negedge clk);
    chk("t1_ack_pulse", {30'd0, req_ack}, 32'd0);
    @(negedge clk);
    chk("t1_ss_hold", {31'd0, ss}, 32'd0);
    @(negedge clk);
    chk("t1_ss_rise", {31'd0, ss}, 32'd1);
    chk("t1_grant_clr", {30'd0, grant}, 32'd0);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    $display("txn single_byte done");

    // Three-byte frame from requester 1
    m_xor = 8'hF0;
    rise0 = ss_rise_cnt;
    req = 2'b10; req_data = 16'h1100; req_last = 2'b00;
    wait_ack("t2_ack1_wait");
    chk("t2_ack1", {30'd0, req_ack}, 32'd2);
    chk("t2_rx1", {24'd0, rx_byte}, 32'hE1);
    req_data = 16'h2200;
    wait_ack("t2_ack2_wait");
    chk("t2_ack2", {30'd0, req_ack}, 32'd2);
    chk("t2_rx2", {24'd0, rx_byte}, 32'hD2);
    req_data = 16'h3300; req_last = 2'b10;
    wait_ack("t2_ack3_wait");
    chk("t2_ack3", {30'd0, req_ack}, 32'd2);
    chk("t2_rx3", {24'd0, rx_byte}, 32'hC3);
    req = 2'b00; req_last = 2'b00;
    wait_idle("t2_idle_wait");
    chk("t2_ss_one_rise", ss_rise_cnt - rise0, 32'd1);
    chk("t2_gap1", gaps[gaps.size()-2], 32'd2);
    chk("t2_gap2", gaps[gaps.size()-1], 32'd2);
    $display("txn three_byte done");

    // Contention: both requesting one-byte frames
    req = 2'b11; req_data = 16'hB00A; req_last = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack("t3_ack_wait");
      chk("t3_grant_order", {30'd0, req_ack}, {30'd0, exp_g[i]});
      chk("t3_rx", {24'd0, rx_byte}, {24'd0, exp_rx[i]});
      $display("txn contention ack %0d", i);
      if (i == 3) req = 2'b00;
    end
    wait_idle("t3_idle_wait");

    // Stall in SEND plus late request from requester 1
    spi_tx_ready = 1'b0;
    req = 2'b01; req_data = 16'h005A; req_last = 2'b01;
    @(negedge clk);
    chk("t4_grant_e0", {30'd0, grant}, 32'd1);
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    repeat (10) @(negedge clk);
    req = 2'b11; req_data = 16'h775A; req_last = 2'b11;
    repeat (10) @(negedge clk);
    chk("t4_no_start", start_cnt - s0, 32'd0);
    chk("t4_ss_low", {31'd0, ss}, 32'd0);
    chk("t4_grant_kept", {30'd0, grant}, 32'd1);
    spi_tx_ready = 1'b1;
    wait_ack("t4_ack0_wait");
    chk("t4_ack0", {30'd0, req_ack}, 32'd1);
    chk("t4_rx0", {24'd0, rx_byte}, 32'hAA);
    req = 2'b10;
    repeat (2) @(negedge clk);
    chk("t4_grant_hold", {30'd0, grant}, 32'd1);
    @(negedge clk);
    chk("t4_grant_clr", {30'd0, grant}, 32'd0);
    chk("t4_ss_rise", {31'd0, ss}, 32'd1);
    @(negedge clk);
    chk("t4_grant_r1", {30'd0, grant}, 32'd2);
    wait_ack("t4_ack1_wait");
    chk("t4_ack1", {30'd0, req_ack}, 32'd2);
    chk("t4_rx1", {24'd0, rx_byte}, 32'h87);
    req = 2'b00;
    wait_idle("t4_idle_wait");
    $display("txn stall_late_req done");

    // Reset mid-frame: first leave ptr at 0, then interrupt a requester 1 frame
    req = 2'b01; req_data = 16'h0042; req_last = 2'b01;
    wait_ack("t5_pre_ack_wait");
    chk("t5_pre_rx", {24'd0, rx_byte}, 32'hB2);
    req = 2'b00;
    wait_idle("t5_pre_idle_wait");
    req = 2'b10; req_data = 16'h9900; req_last = 2'b10;
    wait_start("t5_start_wait");
    @(negedge clk);
    reset = 1'b1;
    req = 2'b11; req_data = 16'h990C; req_last = 2'b11;
    @(negedge clk);
    chk("t5_rst_ss", {31'd0, ss}, 32'd1);
    chk("t5_rst_grant", {30'd0, grant}, 32'd0);
    chk("t5_rst_start", {31'd0, spi_start}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_grant_r0", {30'd0, grant}, 32'd1);
    req = 2'b01;
    wait_ack("t5_ack_wait");
    chk("t5_ack", {30'd0, req_ack}, 32'd1);
    chk("t5_rx", {24'd0, rx_byte}, 32'hFC);
    req = 2'b00;
    wait_idle("t5_idle_wait");
    $display("txn reset_mid_frame done");

`ifdef SPI_ARB_TIMEOUT_EN
    model_done_en = 1'b0;
    req = 2'b01; req_data = 16'h005F; req_last = 2'b01;
    wait_start("t6_start_wait");
    a0 = ack_cnt;
    repeat (15) @(negedge clk);
    chk("t6_err_early", {31'd0, err}, 32'd0);
    @(negedge clk);
    req = 2'b00;
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_ss", {31'd0, ss}, 32'd1);
    chk("t6_grant", {30'd0, grant}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_no_ack", ack_cnt - a0, 32'd0);
    @(negedge clk);
    chk("t6_err_pulse", {31'd0, err}, 32'd0);
    model_done_en = 1'b1;
    $display("txn timeout done");
`else
    chk("err_never", err_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
